// File: rtl/grant_mux_pkg.sv
// Shared types and helpers for the grant-driven burst multiplexer.
// Holds the FSM state encoding, index-width helper and one-hot test.
package grant_mux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int default_num_master = 4;

   function automatic int idx_width_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int idx_width = idx_width_f(default_num_master);

   // True when exactly one bit of v is set; grants wider than 32 are not supported.
   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/grant_burst_mux_onehot_encode.sv
// Combinational one-hot to index encoder with legality flags.
// idx is only meaningful while valid is high.
module onehot_encode
   import grant_mux_pkg::*;
#(
   parameter int n  = 4,
   parameter int iw = 2
) (
   input  logic [n-1:0]  vec,
   output logic [iw-1:0] idx,
   output logic          valid,
   output logic          multi
);

   logic [31:0] ext_s;

   assign ext_s = 32'(vec);

   // OR together the positions of all set bits
   always_comb begin
      idx = '0;
      for (int i = 0; i < n; i++) begin
         if (vec[i]) begin
            idx = idx | iw'(i);
         end else begin
            idx = idx;
         end
      end
   end

   assign valid = is_onehot(ext_s);
   assign multi = (vec != '0) && !valid;

endmodule

// File: rtl/grant_burst_mux.sv
// Locks the arbiter's granted master for one burst and routes its beats
// onto a shared valid/ready slave channel, pulsing done at the end.
module grant_burst_mux
   import grant_mux_pkg::*;
#(
   parameter int num_master = 4,
   parameter int data_width = 8,
   parameter int len_width  = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [num_master-1:0]            grant,
   input  logic [num_master-1:0]            m_valid,
   input  logic [num_master*data_width-1:0] m_data,
   input  logic [num_master*len_width-1:0]  m_len,
   output logic [num_master-1:0]            m_ready,
   output logic                             s_valid,
   output logic [data_width-1:0]            s_data,
   input  logic                             s_ready,
   output logic                             busy,
   output logic [num_master-1:0]            done,
   output logic                             err
);

   localparam int iw = idx_width_f(num_master);

   state_t                state_r, state_s;
   logic [iw-1:0]         owner_r, owner_s;
   logic [len_width-1:0]  cnt_r, cnt_s;
   logic                  err_r, err_s;
   logic [iw-1:0]         enc_idx_s;
   logic                  enc_valid_s;
   logic                  enc_multi_s;
   logic                  beat_s;

   onehot_encode #(
      .n  (num_master),
      .iw (iw)
   ) u_enc (
      .vec   (grant),
      .idx   (enc_idx_s),
      .valid (enc_valid_s),
      .multi (enc_multi_s)
   );

   // Shared-channel pass-through from the locked owner
   always_comb begin
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = '0;
      done    = '0;
      if (state_r == XFER) begin
         s_valid          = m_valid[owner_r];
         m_ready[owner_r] = s_ready;
         if (m_valid[owner_r]) begin
            s_data = m_data[owner_r*data_width +: data_width];
         end else begin
            s_data = '0;
         end
      end else if (state_r == DONE) begin
         done[owner_r] = 1'b1;
      end else begin
         s_valid = 1'b0;
      end
   end

   assign beat_s = s_valid && s_ready;
   assign busy   = (state_r != IDLE);
   assign err    = err_r;

   // Next-state, owner latch and beat counting
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      cnt_s   = cnt_r;
      err_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (enc_valid_s) begin
               owner_s = enc_idx_s;
               cnt_s   = m_len[enc_idx_s*len_width +: len_width];
               state_s = XFER;
            end else if (enc_multi_s) begin
               err_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         XFER: begin
            if (beat_s) begin
               if (cnt_r == '0) begin
                  state_s = DONE;
               end else begin
                  cnt_s = cnt_r - {{(len_width-1){1'b0}}, 1'b1};
               end
            end else begin
               state_s = XFER;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register; reset abandons any burst without a done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         owner_r <= '0;
         cnt_r   <= '0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         cnt_r   <= cnt_s;
         err_r   <= err_s;
      end
   end

endmodule

// File: tb/tb_grant_burst_mux.sv
// Self-checking bench for grant_burst_mux: scoreboard of expected beats
// plus cycle-level checks of lock, done, err and reset behaviour.
module tb_grant_burst_mux;

   logic        clk;
   logic        rst;
   logic [3:0]  grant;
   logic [3:0]  m_valid;
   logic [31:0] m_data;
   logic [7:0]  m_len;
   logic [3:0]  m_ready;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        busy;
   logic [3:0]  done;
   logic        err;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  sb[$];
   logic [7:0]  exp_d;

   grant_burst_mux #(
      .num_master (4),
      .data_width (8),
      .len_width  (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .grant   (grant),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_len   (m_len),
      .m_ready (m_ready),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Beat monitor: every accepted beat must match the next scoreboard entry
   always @(negedge clk) begin
      if (!rst && s_valid && s_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_beat", {24'd0, s_data}, 32'hFFFF_FFFF);
         end else begin
            exp_d = sb.pop_front();
            check("s_data", {24'd0, s_data}, {24'd0, exp_d});
         end
      end
   end

   // Lock master m for nb beats; optional s_ready stall, valid gap,
   // grant switch during XFER and reset after abort_after beats.
   task automatic burst(input int m, input int nb, input logic [31:0] vals,
                        input int stall_at, input int gap_at,
                        input logic [3:0] ng, input int abort_after);
      int stop;
      int beats;
      int stalls;
      int gaps;
      int cyc;
      stop = (abort_after >= 0) ? abort_after : nb;
      for (int k = 0; k < stop; k++) sb.push_back(vals[k*8 +: 8]);
      tick();
      grant          = 4'(1 << m);
      m_len[m*2 +: 2] = 2'(nb - 1);
      m_valid[m]     = 1'b1;
      m_data[m*8 +: 8] = vals[7:0];
      s_ready        = 1'b1;
      @(negedge clk);
      check("idle_before_lock_busy", {31'd0, busy}, 32'd0);
      check("idle_before_lock_svalid", {31'd0, s_valid}, 32'd0);
      tick();
      grant = ng;
      m_len[m*2 +: 2] = ~(2'(nb - 1));
      beats = 0; stalls = 0; gaps = 0; cyc = 0;
      while (beats < stop && cyc < 64) begin
         cyc++;
         m_data[m*8 +: 8] = vals[beats*8 +: 8];
         if (beats == stall_at && stalls < 2) begin
            s_ready = 1'b0;
            stalls++;
         end else begin
            s_ready = 1'b1;
         end
         if (beats == gap_at && gaps < 1) begin
            m_valid[m] = 1'b0;
            gaps++;
         end else begin
            m_valid[m] = 1'b1;
         end
         @(negedge clk);
         check("busy_xfer", {31'd0, busy}, 32'd1);
         check("s_valid_xfer", {31'd0, s_valid}, {31'd0, m_valid[m]});
         check("m_ready_owner", {28'd0, m_ready}, s_ready ? 32'(1 << m) : 32'd0);
         if (!m_valid[m]) check("s_data_zero_when_invalid", {24'd0, s_data}, 32'd0);
         if (s_valid && s_ready) beats++;
         tick();
      end
      check("beat_count", beats, stop);
      if (abort_after >= 0) begin
         rst = 1'b1;
         tick();
         @(negedge clk);
         check("reset_mid_burst_outputs", {busy, err, s_valid, done, m_ready, s_data}, 32'd0);
         tick();
         rst = 1'b0;
         m_valid[m] = 1'b0;
         @(negedge clk);
         check("no_done_after_abort", {27'd0, busy, done}, 32'd0);
      end else begin
         @(negedge clk);
         check("done_pulse", {28'd0, done}, 32'(1 << m));
         check("busy_in_done", {31'd0, busy}, 32'd1);
         check("quiet_in_done", {27'd0, s_valid, m_ready}, 32'd0);
         tick();
         m_valid[m] = 1'b0;
         @(negedge clk);
         check("done_one_cycle", {28'd0, done}, 32'd0);
         check("busy_back_idle", {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      int err_hits;
      rst = 1'b1; grant = 4'd0; m_valid = 4'd0; m_data = 32'd0;
      m_len = 8'd0; s_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("reset_idle_outputs", {busy, err, s_valid, done, m_ready, s_data}, 32'd0);
         tick();
      end

      // single-beat burst on master 2
      burst(2, 1, 32'h0000_00A5, -1, -1, 4'b0000, -1);

      // four beats on master 1 with a two-cycle stall on the second beat
      burst(1, 4, 32'h4433_2211, 1, -1, 4'b0000, -1);

      // grant moves to master 3 while master 1 is locked
      m_valid[3] = 1'b1; m_data[31:24] = 8'hEE; m_len[7:6] = 2'd0;
      burst(1, 3, 32'h00CC_BBAA, -1, 1, 4'b1000, -1);
      sb.push_back(8'hEE);
      tick();
      @(negedge clk);
      check("master3_locked_after_idle", {27'd0, busy, m_ready}, 32'h0000_0018);
      tick();
      grant = 4'd0;
      m_valid[3] = 1'b0;
      @(negedge clk);
      check("master3_done", {28'd0, done}, 32'h0000_0008);
      tick();
      @(negedge clk);
      check("master3_idle", {31'd0, busy}, 32'd0);

      // illegal two-hot grant
      tick();
      grant = 4'b0110;
      err_hits = 0;
      @(negedge clk);
      if (err) err_hits++;
      check("illegal_busy", {27'd0, busy, m_ready}, 32'd0);
      tick();
      grant = 4'd0;
      @(negedge clk);
      if (err) err_hits++;
      check("illegal_stays_idle", {27'd0, busy, m_ready}, 32'd0);
      tick();
      @(negedge clk);
      if (err) err_hits++;
      check("err_single_pulse", err_hits, 1);
      check("err_cleared", {31'd0, err}, 32'd0);

      // reset after two beats of a four-beat burst, then a fresh burst
      burst(3, 4, 32'h0D0C_0B0A, -1, -1, 4'b0000, 2);
      burst(3, 4, 32'h4D3C_2B1A, -1, -1, 4'b0000, -1);

      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/grant_burst_mux.md
Name: grant_burst_mux

Overview:
- Sits directly downstream of the num_master-way arbiter and consumes its one-hot grant vector.
- Locks the granted master as bus owner for one complete burst.
- Routes the owner's data onto a single shared slave channel with a valid/ready handshake.
- Pulses a per-master done bit so masters can drop req and the arbiter can re-arbitrate.

Parameters:
- num_master, 4, number of masters; must match the arbiter's num_master.
- data_width, 8, width of one data beat.
- len_width, 2, width of the per-master burst-length field; burst beats = len+1, so 1 to 2**len_width.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- grant  input  num_master  one-hot grant from arbiter; sampled only in IDLE.
- m_valid  input  num_master  per-master beat valid.
- m_data  input  num_master*data_width  per-master data, master i at bits [i*data_width +: data_width].
- m_len  input  num_master*len_width  per-master burst length minus one, same packing.
- m_ready  output  num_master  per-master beat accept; only owner bit can be 1.
- s_valid  output  1  shared channel beat valid.
- s_data  output  data_width  shared channel data.
- s_ready  input  1  shared channel accept.
- busy  output  1  high while a burst is locked.
- done  output  num_master  one-cycle one-hot pulse to owner after its last beat.
- err  output  1  one-cycle pulse: grant in IDLE had more than one bit set.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, owner=0, beat counter=0.
  - Outputs: m_ready=0, s_valid=0, s_data=0, busy=0, done=0, err=0.
  - Applies from any state; a burst in progress is abandoned with no done pulse.
- States: IDLE, XFER, DONE.
- IDLE:
  - grant==0: stay IDLE.
  - grant exactly one-hot: latch owner index and cnt=m_len[owner]; go to XFER next edge.
  - grant has 2+ bits set: err=1 for one cycle, stay IDLE, latch nothing.
- XFER:
  - Combinational pass-through, zero latency: s_valid=m_valid[owner], s_data=m_data[owner], m_ready[owner]=s_ready. All other m_ready bits are 0.
  - A beat occurs on a cycle with s_valid&&s_ready.
  - Beat with cnt!=0: cnt decrements. Beat with cnt==0: go to DONE.
  - Valid low or ready low: hold, no count. Stalls are unbounded.
  - grant changes are ignored while locked.
  - s_data is 0 whenever s_valid=0.
- DONE: done[owner]=1 for exactly one cycle; m_ready=0, s_valid=0; go to IDLE unconditionally.
- busy=1 in XFER and DONE, 0 in IDLE.
- Throughput: a new grant sampled in the IDLE cycle after DONE gives a minimum of 2 idle cycles between bursts (DONE, IDLE).
- Owner's m_valid dropping mid-burst: stall, not abort.
- m_len is sampled only at lock; later changes have no effect on the current burst.
- Width rules: owner index is $clog2(num_master) bits. cnt is len_width bits with no wrap; a decrement at 0 cannot occur because that beat exits XFER.

Decomposition:
- Package grant_mux_pkg:
  - state enum (IDLE, XFER, DONE), 2-bit logic.
  - localparam idx_width=$clog2(num_master) helper.
  - function returning popcount-is-one for a grant vector.
- Sub-module onehot_encode (combinational):
  - Input: num_master-bit vector.
  - Outputs: idx, valid (exactly one bit set), multi (2+ bits set).
  - Used in IDLE for owner latch and err.

Test Plan:
- Reset then idle: rst=1 for 2 cycles then 0, grant=0 -> all outputs 0, busy=0 for 5 cycles.
- Single-beat burst: grant=0100, m_len[2]=0, m_valid[2]=1, m_data[2]=8'hA5, s_ready=1 -> next cycle s_valid=1, s_data=A5, m_ready=0100; following cycle done=0100, busy=1; then busy=0.
- Stalled multi-beat burst: grant=0010, m_len[1]=3, data 11,22,33,44, s_ready low on 2nd beat for 2 cycles -> exactly 4 beats in order; no beat counted while s_ready=0; done=0010 one cycle after the 4th beat.
- Grant change mid-burst: lock master 1 with m_len=2, then switch grant to 1000 during XFER -> s_data still from master 1, m_ready[3]=0 until master 1 done; master 3 is locked only after return to IDLE.
- Illegal grant: grant=0110 in IDLE -> err=1 for one cycle, busy=0, m_ready=0, state stays IDLE.
- Reset mid-burst: lock master 3, m_len=3, assert rst after 2 beats -> next edge all outputs 0, no done pulse; a later grant=1000 starts a fresh 4-beat burst.
